// File: rtl/weight_loader_pkg.sv
// Shared constants and loader state encoding for the weight_loader block.
// The CHK state is always encoded; it is only reachable when CHECKSUM_EN is defined.
package weight_loader_pkg;

  localparam int NUM_PIXELS     = 784;
  localparam int NUM_CLASSES    = 10;
  localparam int NUM_WEIGHTS    = NUM_PIXELS * NUM_CLASSES;
  localparam int NUM_BIAS_BYTES = NUM_CLASSES * 4;
  localparam int WADDR_W        = 13;

  localparam logic [7:0] SOF = 8'hAA;
  localparam logic [7:0] EOF = 8'h55;

  typedef enum logic [2:0] {
    IDLE,
    WEIGHTS,
    BIAS,
    CHK,
    TRAIL,
    READY,
    ERROR
  } load_state_e;

endpackage

// File: rtl/weight_loader_ram.sv
// 7840x8 simple dual-port synchronous RAM: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM; read-during-write returns old data.
module weight_ram
  import weight_loader_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [WADDR_W-1:0] waddr,
  input  logic [7:0]         wdata,
  input  logic               re,
  input  logic [WADDR_W-1:0] raddr,
  output logic [7:0]         rdata
);

  logic [7:0] mem [NUM_WEIGHTS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/weight_loader.sv
// Framed parameter loader: SOF, 7840 weights, 40 bias bytes, [checksum], EOF.
// Define CHECKSUM_EN to add the XOR checksum byte and the CHK state.
//
//   state   | meaning
//   IDLE    | after reset, waiting for SOF
//   WEIGHTS | writing weight bytes into RAM
//   BIAS    | assembling little-endian 32-bit biases
//   CHK     | comparing received checksum with accumulated XOR
//   TRAIL   | expecting EOF
//   READY   | frame accepted, parameters valid
//   ERROR   | frame aborted (trailer, checksum or timeout)
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic [WADDR_W-1:0] weight_addr,
  output logic [7:0]         weight_data,
  input  logic [3:0]         bias_addr,
  output logic [31:0]        bias_data,
  output logic               weights_ready,
  output logic               load_error,
  output logic               loading
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

  load_state_e         state, state_nxt;
  logic [WADDR_W-1:0]  wcnt;
  logic [5:0]          bcnt;
  logic [23:0]         asm_q;
  logic [31:0]         bias_q [NUM_CLASSES];
  logic [TMR_W-1:0]    tmr_q;
  logic                wr_en, bias_en, frame_start, rd_ok_q;
  logic [7:0]          ram_rdata;
`ifdef CHECKSUM_EN
  logic [7:0]          chk_q;
`endif

  assign wr_en         = (state == WEIGHTS) && rx_valid;
  assign bias_en       = (state == BIAS) && rx_valid;
  assign frame_start   = (state_nxt == WEIGHTS) && (state != WEIGHTS);
  assign loading       = (state == WEIGHTS) || (state == BIAS) || (state == CHK) || (state == TRAIL);
  assign weights_ready = (state == READY);
  assign load_error    = (state == ERROR);
  assign weight_data   = rd_ok_q ? ram_rdata : 8'h00;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, READY, ERROR:
        if (rx_valid && rx_data == SOF) state_nxt = WEIGHTS;
      WEIGHTS:
        if (rx_valid && wcnt == WADDR_W'(NUM_WEIGHTS - 1)) state_nxt = BIAS;
      BIAS:
`ifdef CHECKSUM_EN
        if (rx_valid && bcnt == 6'(NUM_BIAS_BYTES - 1)) state_nxt = CHK;
      CHK:
        if (rx_valid) state_nxt = (rx_data == chk_q) ? TRAIL : ERROR;
`else
        if (rx_valid && bcnt == 6'(NUM_BIAS_BYTES - 1)) state_nxt = TRAIL;
`endif
      TRAIL:
        if (rx_valid) state_nxt = (rx_data == EOF) ? READY : ERROR;
      default:
        state_nxt = IDLE;
    endcase
    // idle down-counter hitting zero aborts any frame in progress
    if (loading && !rx_valid && tmr_q == '0) state_nxt = ERROR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      bcnt  <= '0;
      asm_q <= '0;
      tmr_q <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) bias_q[i] <= '0;
`ifdef CHECKSUM_EN
      chk_q <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (rx_valid)          tmr_q <= TMR_LOAD;
      else if (tmr_q != '0)  tmr_q <= tmr_q - 1'b1;
      if (frame_start) begin
        wcnt <= '0;
        bcnt <= '0;
`ifdef CHECKSUM_EN
        chk_q <= '0;
`endif
      end else begin
        if (wr_en) wcnt <= wcnt + 1'b1;
        if (bias_en) begin
          bcnt <= bcnt + 1'b1;
          case (bcnt[1:0])
            2'd0:    asm_q[7:0]   <= rx_data;
            2'd1:    asm_q[15:8]  <= rx_data;
            2'd2:    asm_q[23:16] <= rx_data;
            default: bias_q[bcnt[5:2]] <= {rx_data, asm_q};
          endcase
        end
`ifdef CHECKSUM_EN
        if (wr_en || bias_en) chk_q <= chk_q ^ rx_data;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ok_q   <= 1'b0;
      bias_data <= '0;
    end else begin
      rd_ok_q   <= (weight_addr < WADDR_W'(NUM_WEIGHTS));
      bias_data <= (bias_addr < 4'(NUM_CLASSES)) ? bias_q[bias_addr] : 32'h0;
    end
  end

  weight_ram u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wcnt),
    .wdata (rx_data),
    .re    (weight_addr < WADDR_W'(NUM_WEIGHTS)),
    .raddr (weight_addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with a short timeout; frames carry a checksum when CHECKSUM_EN is defined.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [12:0] weight_addr;
  logic [7:0]  weight_data;
  logic [3:0]  bias_addr;
  logic [31:0] bias_data;
  logic        weights_ready, load_error, loading;

  int checks = 0;
  int errors = 0;
  logic [7:0] xacc;

  always #5 clk = ~clk;

  weight_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .weight_addr   (weight_addr),
    .weight_data   (weight_data),
    .bias_addr     (bias_addr),
    .bias_data     (bias_data),
    .weights_ready (weights_ready),
    .load_error    (load_error),
    .loading       (loading)
  );

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_frame();
    xacc = 8'h00;
    send_byte(8'hAA);
  endtask

  task automatic send_weights(input int mode, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = (mode == 1) ? 8'h7F : 8'(i % 256);
      xacc = xacc ^ b;
      send_byte(b);
    end
  endtask

  task automatic send_tail(input int mul, input logic [7:0] trailer, input logic bad_chk);
    logic [31:0] v;
    for (int k = 0; k < 10; k++) begin
      v = 32'(k * mul);
      for (int j = 0; j < 4; j++) begin
        xacc = xacc ^ v[8*j +: 8];
        send_byte(v[8*j +: 8]);
      end
    end
`ifdef CHECKSUM_EN
    send_byte(bad_chk ? (xacc ^ 8'h01) : xacc);
`else
    if (bad_chk) xacc = ~xacc;
`endif
    send_byte(trailer);
  endtask

  task automatic rd(input logic [12:0] wa, input logic [3:0] ba);
    weight_addr = wa;
    bias_addr   = ba;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    weight_addr = 13'd0;
    bias_addr = 4'd0;
    repeat (3) @(negedge clk);
    checks++; if (weights_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", weights_ready); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", load_error); end
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading got %b want 0", loading); end
    checks++; if (weight_data !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", weight_data); end
    checks++; if (bias_data !== 32'h0) begin errors++; $display("FAIL reset_bdata got %h want 0", bias_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_valid_frame();
    send_byte(8'h13);
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL idle_ignore got %b want 0", loading); end
    start_frame();
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL vf_loading got %b want 1", loading); end
    send_weights(0, 7840);
    send_tail(1000, 8'h55, 1'b0);
    checks++; if (weights_ready !== 1'b1) begin errors++; $display("FAIL vf_ready got %b want 1", weights_ready); end
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL vf_loading_end got %b want 0", loading); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL vf_error got %b want 0", load_error); end
    rd(13'd1000, 4'd7);
    checks++; if (weight_data !== 8'hE8) begin errors++; $display("FAIL vf_w1000 got %h want e8", weight_data); end
    checks++; if (bias_data !== 32'd7000) begin errors++; $display("FAIL vf_b7 got %0d want 7000", bias_data); end
    rd(13'd7839, 4'd9);
    checks++; if (weight_data !== 8'h9F) begin errors++; $display("FAIL vf_w7839 got %h want 9f", weight_data); end
    checks++; if (bias_data !== 32'd9000) begin errors++; $display("FAIL vf_b9 got %0d want 9000", bias_data); end
    rd(13'd170, 4'd1);
    checks++; if (weight_data !== 8'hAA) begin errors++; $display("FAIL vf_w170 got %h want aa", weight_data); end
    checks++; if (bias_data !== 32'd1000) begin errors++; $display("FAIL vf_b1 got %0d want 1000", bias_data); end
  endtask

  task automatic test_bad_trailer();
    start_frame();
    send_weights(0, 7840);
    send_tail(1000, 8'h54, 1'b0);
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL bt_error got %b want 1", load_error); end
    checks++; if (weights_ready !== 1'b0) begin errors++; $display("FAIL bt_ready got %b want 0", weights_ready); end
    start_frame();
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL bt_restart_error got %b want 0", load_error); end
    send_weights(0, 7840);
    send_tail(2, 8'h55, 1'b0);
    checks++; if (weights_ready !== 1'b1) begin errors++; $display("FAIL bt_recover_ready got %b want 1", weights_ready); end
    rd(13'd0, 4'd5);
    checks++; if (bias_data !== 32'd10) begin errors++; $display("FAIL bt_b5 got %0d want 10", bias_data); end
  endtask

  task automatic test_timeout();
    start_frame();
    send_weights(0, 5000);
    repeat (95) @(negedge clk);
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL to_early_loading got %b want 1", loading); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL to_early_error got %b want 0", load_error); end
    repeat (10) @(negedge clk);
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL to_error got %b want 1", load_error); end
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL to_loading got %b want 0", loading); end
  endtask

  task automatic test_reload();
    start_frame();
    send_weights(0, 7840);
    send_tail(1000, 8'h55, 1'b0);
    checks++; if (weights_ready !== 1'b1) begin errors++; $display("FAIL rl_ready_before got %b want 1", weights_ready); end
    start_frame();
    checks++; if (weights_ready !== 1'b0) begin errors++; $display("FAIL rl_ready_drop got %b want 0", weights_ready); end
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL rl_loading got %b want 1", loading); end
    send_weights(1, 7840);
    send_tail(3, 8'h55, 1'b0);
    checks++; if (weights_ready !== 1'b1) begin errors++; $display("FAIL rl_ready got %b want 1", weights_ready); end
    rd(13'd7839, 4'd4);
    checks++; if (weight_data !== 8'h7F) begin errors++; $display("FAIL rl_w7839 got %h want 7f", weight_data); end
    checks++; if (bias_data !== 32'd12) begin errors++; $display("FAIL rl_b4 got %0d want 12", bias_data); end
  endtask

  task automatic test_oob_reset();
    rd(13'd8000, 4'd12);
    checks++; if (weight_data !== 8'h00) begin errors++; $display("FAIL oob_w got %h want 00", weight_data); end
    checks++; if (bias_data !== 32'h0) begin errors++; $display("FAIL oob_b got %h want 0", bias_data); end
    start_frame();
    send_weights(0, 3000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL rst_loading got %b want 0", loading); end
    checks++; if (weights_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", weights_ready); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", load_error); end
    rd(13'd10, 4'd4);
    checks++; if (weight_data !== 8'h0A) begin errors++; $display("FAIL rst_partial_w got %h want 0a", weight_data); end
    checks++; if (bias_data !== 32'h0) begin errors++; $display("FAIL rst_bias_clr got %h want 0", bias_data); end
    rd(13'd5000, 4'd0);
    checks++; if (weight_data !== 8'h7F) begin errors++; $display("FAIL rst_keep_w got %h want 7f", weight_data); end
    send_byte(8'h55);
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL rst_idle_ignore got %b want 0", loading); end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    start_frame();
    send_weights(0, 7840);
    send_tail(500, 8'h55, 1'b1);
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL ck_bad_error got %b want 1", load_error); end
    checks++; if (weights_ready !== 1'b0) begin errors++; $display("FAIL ck_bad_ready got %b want 0", weights_ready); end
    start_frame();
    send_weights(0, 7840);
    send_tail(500, 8'h55, 1'b0);
    checks++; if (weights_ready !== 1'b1) begin errors++; $display("FAIL ck_good_ready got %b want 1", weights_ready); end
    rd(13'd0, 4'd3);
    checks++; if (bias_data !== 32'd1500) begin errors++; $display("FAIL ck_b3 got %0d want 1500", bias_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_trailer();
    test_timeout();
    test_reload();
    test_oob_reset();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
